// File: rtl/zero_channel_pkg.sv
// zero_channel_pkg: shared word width, out-channel capacity default and checker states
package zero_channel_pkg;
  localparam int MemoryElementWidth = 12;
  localparam int NOUT_DEFAULT = 8;
  typedef enum logic [1:0] {COLLECT, CHECK, DONE} state_t;
endpackage

// File: rtl/out_channel_checker_if.sv
// out_channel_checker_if: executor out-channel, expected-table write port and checker results
interface out_channel_checker_if
  import zero_channel_pkg::*;
#(
  parameter int W = MemoryElementWidth,
  parameter int N = NOUT_DEFAULT
);
  localparam int CW = $clog2(N + 1);
  localparam int AW = N > 1 ? $clog2(N) : 1;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          outReady;
  logic          programFinished;
  logic          expWrite;
  logic [AW-1:0] expIndex;
  logic [W-1:0]  expData;
  logic [CW-1:0] expCount;
  logic          finished;
  logic          success;
  logic [CW-1:0] received;
  modport master (
    output outValid, outData, programFinished, expWrite, expIndex, expData, expCount,
    input  outReady, finished, success, received
  );
  modport slave (
    input  outValid, outData, programFinished, expWrite, expIndex, expData, expCount,
    output outReady, finished, success, received
  );
endinterface

// File: rtl/out_channel_ram.sv
// out_channel_ram: N x W storage, one write port and one combinational read port, no reset
module out_channel_ram #(
  parameter int W  = 12,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [N];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/out_channel_checker.sv
// out_channel_checker: collects executor out words, then compares them one per cycle with the expected table
module out_channel_checker #(
  parameter int MemoryElementWidth = zero_channel_pkg::MemoryElementWidth,
  parameter int NOut = zero_channel_pkg::NOUT_DEFAULT
) (
  input logic clock,
  input logic reset,
  out_channel_checker_if.slave bus
);
  import zero_channel_pkg::*;
  localparam int CW = $clog2(NOut + 1);
  localparam int AW = NOut > 1 ? $clog2(NOut) : 1;
  state_t r_state, w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_received, r_k, r_exp_cnt;
  logic r_overflow, r_ok, r_finished, r_success;
  logic [MemoryElementWidth-1:0] w_buf_q, w_exp_q;
  logic w_accept, w_last, w_match;
  assign bus.outReady = !reset && r_state == COLLECT;
  assign w_accept = bus.outValid && bus.outReady;
  // CHECK always spends at least one cycle, even with nothing to compare
  assign w_last = r_k + CW'(1) >= r_exp_cnt;
  assign w_match = r_k >= r_exp_cnt || w_buf_q == w_exp_q;
  assign bus.finished = r_finished;
  assign bus.success = r_success;
  assign bus.received = r_received;
  always_comb begin
    w_next = r_state == COLLECT && bus.programFinished ? CHECK :
             r_state == CHECK && w_last ? DONE : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= COLLECT;
    else r_state <= w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_received <= '0;
      r_overflow <= 1'b0;
      r_ok <= 1'b1;
      r_finished <= 1'b0;
      r_success <= 1'b0;
      r_k <= '0;
      r_exp_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr == AW'(NOut - 1) ? '0 : r_wr_ptr + AW'(1);
        if (r_received == CW'(NOut)) r_overflow <= 1'b1;
        else r_received <= r_received + CW'(1);
      end
      if (r_state == COLLECT && bus.programFinished) begin
        r_exp_cnt <= bus.expCount;
        r_k <= '0;
      end
      if (r_state == CHECK) begin
        r_k <= r_k + CW'(1);
        r_ok <= r_ok && w_match;
        if (w_last) begin
          r_finished <= 1'b1;
          r_success <= r_ok && w_match && !r_overflow && r_received == r_exp_cnt &&
                       r_exp_cnt <= CW'(NOut);
        end
      end
    end
  end
  out_channel_ram #(.W(MemoryElementWidth), .N(NOut), .AW(AW)) u_out_buf (
    .clk(clock), .i_we(w_accept), .i_waddr(r_wr_ptr), .i_wdata(bus.outData),
    .i_raddr(r_k[AW-1:0]), .o_rdata(w_buf_q)
  );
  out_channel_ram #(.W(MemoryElementWidth), .N(NOut), .AW(AW)) u_exp_tab (
    .clk(clock), .i_we(bus.expWrite), .i_waddr(bus.expIndex), .i_wdata(bus.expData),
    .i_raddr(r_k[AW-1:0]), .o_rdata(w_exp_q)
  );
endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: directed scenarios on a 4-entry checker with hand-computed results
module tb_out_channel_checker;
  import zero_channel_pkg::*;
  localparam int W = MemoryElementWidth;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  out_channel_checker_if #(.W(W), .N(N)) bus ();
  out_channel_checker #(.MemoryElementWidth(W), .NOut(N)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic send(input int d);
    bus.outValid = 1'b1;
    bus.outData = W'(d);
    tick();
    bus.outValid = 1'b0;
  endtask
  task automatic wr_exp(input int idx, input int d);
    bus.expWrite = 1'b1;
    bus.expIndex = 2'(idx);
    bus.expData = W'(d);
    tick();
    bus.expWrite = 1'b0;
  endtask
  task automatic finish_prog();
    bus.programFinished = 1'b1;
    tick();
    bus.programFinished = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    bus.outValid = 1'b0;
    bus.outData = '0;
    bus.programFinished = 1'b0;
    bus.expWrite = 1'b0;
    bus.expIndex = '0;
    bus.expData = '0;
    bus.expCount = '0;
    ticks(2);
    chk("rst_ready", bus.outReady, 0);
    chk("rst_finished", bus.finished, 0);
    chk("rst_success", bus.success, 0);
    chk("rst_received", bus.received, 0);
    reset = 1'b0;
    #1;
    chk("collect_ready", bus.outReady, 1);
    // single matching word
    wr_exp(0, 2);
    bus.expCount = 1;
    send(2);
    chk("s1_received", bus.received, 1);
    finish_prog();
    chk("s1_busy", bus.finished, 0);
    chk("s1_check_ready", bus.outReady, 0);
    tick();
    chk("s1_finished", bus.finished, 1);
    chk("s1_success", bus.success, 1);
    chk("s1_received_end", bus.received, 1);
    bus.outValid = 1'b1;
    bus.outData = 7;
    bus.programFinished = 1'b1;
    #1;
    chk("s1_done_ready", bus.outReady, 0);
    tick();
    bus.outValid = 1'b0;
    bus.programFinished = 1'b0;
    chk("s1_done_received", bus.received, 1);
    chk("s1_hold_finished", bus.finished, 1);
    chk("s1_hold_success", bus.success, 1);
    // middle word mismatches
    do_reset();
    chk("s2_rst_finished", bus.finished, 0);
    chk("s2_rst_success", bus.success, 0);
    wr_exp(0, 5);
    wr_exp(1, 6);
    wr_exp(2, 7);
    bus.expCount = 3;
    send(5);
    send(9);
    send(7);
    finish_prog();
    ticks(2);
    chk("s2_busy", bus.finished, 0);
    tick();
    chk("s2_finished", bus.finished, 1);
    chk("s2_success", bus.success, 0);
    chk("s2_received", bus.received, 3);
    // six words into four entries overflows
    do_reset();
    for (int i = 0; i < 4; i++) wr_exp(i, i + 1);
    bus.expCount = 4;
    for (int i = 1; i <= 6; i++) send(i);
    chk("s3_received", bus.received, 4);
    chk("s3_ready", bus.outReady, 1);
    finish_prog();
    ticks(3);
    chk("s3_busy", bus.finished, 0);
    tick();
    chk("s3_finished", bus.finished, 1);
    chk("s3_success", bus.success, 0);
    chk("s3_received_end", bus.received, 4);
    // exactly full, no overflow
    do_reset();
    for (int i = 1; i <= 4; i++) send(i);
    finish_prog();
    ticks(4);
    chk("s3b_finished", bus.finished, 1);
    chk("s3b_success", bus.success, 1);
    chk("s3b_received", bus.received, 4);
    // count mismatch, then empty run
    do_reset();
    bus.expCount = 2;
    send(1);
    finish_prog();
    ticks(2);
    chk("s4_finished", bus.finished, 1);
    chk("s4_success", bus.success, 0);
    do_reset();
    bus.expCount = 0;
    finish_prog();
    chk("s4_empty_busy", bus.finished, 0);
    tick();
    chk("s4_empty_finished", bus.finished, 1);
    chk("s4_empty_success", bus.success, 1);
    chk("s4_empty_received", bus.received, 0);
    // word on the same cycle as programFinished
    do_reset();
    wr_exp(0, 4);
    bus.expCount = 1;
    bus.outValid = 1'b1;
    bus.outData = 4;
    bus.programFinished = 1'b1;
    tick();
    bus.outValid = 1'b0;
    bus.programFinished = 1'b0;
    chk("s5_received", bus.received, 1);
    chk("s5_ready", bus.outReady, 0);
    tick();
    chk("s5_finished", bus.finished, 1);
    chk("s5_success", bus.success, 1);
    // reset during CHECK, rerun on retained table {4,2,3,4}
    do_reset();
    bus.expCount = 3;
    send(4);
    send(2);
    send(3);
    finish_prog();
    tick();
    reset = 1'b1;
    #1;
    chk("s6_rst_ready", bus.outReady, 0);
    tick();
    chk("s6_rst_finished", bus.finished, 0);
    chk("s6_rst_received", bus.received, 0);
    reset = 1'b0;
    ticks(3);
    chk("s6_no_pulse", bus.finished, 0);
    send(4);
    send(2);
    send(3);
    finish_prog();
    ticks(2);
    chk("s6_busy", bus.finished, 0);
    tick();
    chk("s6_finished", bus.finished, 1);
    chk("s6_success", bus.success, 1);
    chk("s6_received", bus.received, 3);
    // rewriting exp[0] during its own comparison cycle does not alter it
    do_reset();
    bus.expCount = 2;
    send(4);
    send(2);
    finish_prog();
    wr_exp(0, 9);
    tick();
    chk("s7_finished", bus.finished, 1);
    chk("s7_success", bus.success, 1);
    do_reset();
    bus.expCount = 1;
    send(4);
    finish_prog();
    tick();
    chk("s7_new_exp_finished", bus.finished, 1);
    chk("s7_new_exp_success", bus.success, 0);
    // expCount above capacity
    do_reset();
    bus.expCount = 5;
    for (int i = 1; i <= 4; i++) send(i);
    finish_prog();
    ticks(4);
    chk("s8_busy", bus.finished, 0);
    tick();
    chk("s8_finished", bus.finished, 1);
    chk("s8_success", bus.success, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/out_channel_checker.md
OUT_CHANNEL_CHECKER -- requirements
Module: out_channel_checker

Interface
REQ-001 The block SHALL provide parameters: MemoryElementWidth, default 12, word width; NOut, default 8, out-channel capacity (1..256); CW = $clog2(NOut+1), derived, counter width.
REQ-002 The block SHALL have ports: clock  input  1  single clock for all state.
REQ-003 The block SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports: outValid  input  1  executor presents an out word.
REQ-005 The block SHALL have ports: outData  input  MemoryElementWidth  out word value.
REQ-006 The block SHALL have ports: outReady  output  1  checker accepts a word this cycle.
REQ-007 The block SHALL have ports: programFinished  input  1  executor has finished (level; first high cycle counts).
REQ-008 The block SHALL have ports: expWrite  input  1; expIndex  input  $clog2(NOut); expData  input  MemoryElementWidth  expected-table write port.
REQ-009 The block SHALL have ports: expCount  input  CW  number of expected words, sampled on entry to CHECK.
REQ-010 The block SHALL have ports: finished  output  1; success  output  1; received  output  CW  words accepted (saturating at NOut).

Function
REQ-011 The block SHALL implement states COLLECT, CHECK, DONE, with COLLECT entered from reset.
REQ-012 In COLLECT, outReady SHALL be 1, and a word SHALL be accepted on any cycle where outValid && outReady.
REQ-013 Each accepted word SHALL be written to buf[wrPtr], with wrPtr = (wrPtr+1) mod NOut, matching executor wrap semantics.
REQ-014 Accepting a word while received == NOut SHALL overwrite the oldest entry and set the sticky overflow flag; received SHALL stay at NOut.
REQ-015 programFinished high in COLLECT SHALL move the state to CHECK on the next edge; a word accepted on that same cycle SHALL be stored and counted.
REQ-016 In CHECK, outReady SHALL be 0; the block SHALL compare buf[k] with exp[k] for one index k per cycle, k = 0..expCount-1; any mismatch SHALL clear the ok flag.
REQ-017 The CHECK state SHALL last max(expCount,1) cycles and then move to DONE.
REQ-018 On entering DONE, the block SHALL set finished=1 and success = ok && !overflow && (received == expCount); both outputs SHALL hold until reset.
REQ-019 In DONE, outReady SHALL be 0 and outValid/programFinished SHALL be ignored.
REQ-020 Latency from the first programFinished cycle to finished=1 SHALL be max(expCount,1)+1 cycles.
REQ-021 A write to the expected table SHALL take effect on the next edge in any state; a write to index k during CHECK at or after its comparison SHALL NOT alter that comparison.
REQ-022 expCount > NOut SHALL force success=0.

Reset
REQ-023 While reset is high at a clock edge, the block SHALL set state=COLLECT, wrPtr=0, received=0, overflow=0, ok=1, finished=0, success=0, and outReady=0 during the reset cycle.
REQ-024 Reset SHALL NOT clear the buf or exp contents; the expected table SHALL survive reset.
REQ-025 Reset asserted mid-COLLECT or mid-CHECK SHALL abandon the run with no finished pulse.

Structure
REQ-026 A shared package zero_channel_pkg SHALL hold MemoryElementWidth, the NOut default, and the state enum (COLLECT, CHECK, DONE).
REQ-027 Storage SHALL be one sub-module, out_channel_ram, instantiated twice (buf, exp), each with 1 write port and 1 combinational read port of NOut x MemoryElementWidth.

Verification
REQ-028 Scenario 1: expCount=1, exp[0]=2; send 2; assert programFinished -> finished=1 two cycles later, success=1, received=1.
REQ-029 Scenario 2: expCount=3, exp={5,6,7}; send 5,9,7 -> finished after 4 cycles, success=0.
REQ-030 Scenario 3: NOut=4, expCount=4; send 6 words 1..6 -> overflow set, received=4, success=0.
REQ-031 Scenario 4: expCount=2; send only word 1 -> success=0 (count mismatch); then expCount=0 with no words -> finished after 2 cycles, success=1.
REQ-032 Scenario 5: outValid with word 4 on the same cycle as programFinished, expCount=1, exp[0]=4 -> word counted, success=1.
REQ-033 Scenario 6: reset asserted during CHECK -> finished=0, received=0 next cycle; rerun with the retained exp table passes.
